// File: rtl/axi_req_arbiter.sv
// Round-robin arbiter funnelling N_REQ cache/PTW requesters onto one AXI adapter port,
// one transaction in flight. Optional WAIT_RSP watchdog: define AXI_ARB_TIMEOUT_EN.
module axi_req_arbiter #(
  parameter  int N_REQ        = 3,
  parameter  int DATA_WIDTH   = 256,
  parameter  int AXI_ID_WIDTH = 10,
  parameter  int ARB_TIMEOUT  = 1024,
  parameter  int ADDR_WIDTH   = 64,
  parameter  int SIZE_WIDTH   = 3,
  localparam int BE_WIDTH     = DATA_WIDTH / 8,
  localparam int SEL_W        = $clog2(N_REQ)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [N_REQ-1:0]                       req_i,
  input  logic [N_REQ-1:0]                       type_i,
  input  logic [N_REQ-1:0]                       we_i,
  input  logic [N_REQ-1:0][SIZE_WIDTH-1:0]       size_i,
  input  logic [N_REQ-1:0][AXI_ID_WIDTH-1:0]     id_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]       addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]       wdata_i,
  input  logic [N_REQ-1:0][BE_WIDTH-1:0]         be_i,
  output logic [N_REQ-1:0]                       gnt_o,
  output logic [N_REQ-1:0]                       valid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic [AXI_ID_WIDTH-1:0]                id_o,
  output logic [N_REQ-1:0]                       err_o,
  output logic                                   busy_o,
  output logic                                   ad_req_o,
  output logic                                   ad_type_o,
  output logic                                   ad_we_o,
  output logic [SIZE_WIDTH-1:0]                  ad_size_o,
  output logic [AXI_ID_WIDTH-1:0]                ad_id_o,
  output logic [ADDR_WIDTH-1:0]                  ad_addr_o,
  output logic [DATA_WIDTH-1:0]                  ad_wdata_o,
  output logic [BE_WIDTH-1:0]                    ad_be_o,
  input  logic                                   ad_gnt_i,
  input  logic                                   ad_valid_i,
  input  logic [DATA_WIDTH-1:0]                  ad_rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]                ad_id_i
);

  if (N_REQ < 2 || N_REQ > 8 || ARB_TIMEOUT < 2) begin : g_param_check
    $error("axi_req_arbiter: N_REQ must be 2..8 and ARB_TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {IDLE, FWD, WAIT_RSP} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, rr_q, rr_d, rr_nxt, winner, fsel;
  logic [SEL_W:0]   idx;
  logic             found, to_expire;

  // First requester at or above rr_q, wrapping past N_REQ-1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_q} + (SEL_W+1)'(i);
      if (idx >= (SEL_W+1)'(N_REQ)) idx = idx - (SEL_W+1)'(N_REQ);
      if (!found && req_i[idx[SEL_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[SEL_W-1:0];
      end
    end
  end

  assign rr_nxt = (sel_q == SEL_W'(N_REQ-1)) ? '0 : sel_q + 1'b1;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(ARB_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        to_cnt_q <= '0;
    else if (state_q == FWD && ad_gnt_i) to_cnt_q <= '0;
    else if (state_q == WAIT_RSP)       to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign to_expire = (state_q == WAIT_RSP) && (to_cnt_q == TO_W'(ARB_TIMEOUT-1));
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

  // A grant and a response in the same FWD cycle count as grant only.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    gnt_o    = '0;
    valid_o  = '0;
    err_o    = '0;
    ad_req_o = 1'b0;
    unique case (state_q)
      IDLE: if (found) begin
        sel_d   = winner;
        state_d = FWD;
      end
      FWD: begin
        ad_req_o     = 1'b1;
        gnt_o[sel_q] = ad_gnt_i;
        if (ad_gnt_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        valid_o[sel_q] = ad_valid_i;
        if (ad_valid_i) begin
          rr_d    = rr_nxt;
          state_d = IDLE;
        end else if (to_expire) begin
          err_o[sel_q] = 1'b1;
          rr_d         = rr_nxt;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fields park on requester 0 whenever no request is being forwarded.
  assign fsel       = (state_q == FWD) ? sel_q : '0;
  assign ad_type_o  = type_i[fsel];
  assign ad_we_o    = we_i[fsel];
  assign ad_size_o  = size_i[fsel];
  assign ad_id_o    = id_i[fsel];
  assign ad_addr_o  = addr_i[fsel];
  assign ad_wdata_o = wdata_i[fsel];
  assign ad_be_o    = be_i[fsel];

  assign busy_o  = (state_q != IDLE);
  assign rdata_o = ad_rdata_i;
  assign id_o    = ad_id_i;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Scoreboard bench for axi_req_arbiter: directed scenarios push expected grants,
// responses and timeouts; a negedge monitor pops and compares them.
module tb_axi_req_arbiter;

  localparam int N = 3;
  localparam int DW = 256;
  localparam int IW = 10;
  localparam int AW = 64;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [N-1:0]          req_i = '0, type_i = '0, we_i = 3'b010;
  logic [N-1:0][2:0]     size_i;
  logic [N-1:0][IW-1:0]  id_i;
  logic [N-1:0][AW-1:0]  addr_i;
  logic [N-1:0][DW-1:0]  wdata_i;
  logic [N-1:0][DW/8-1:0] be_i;
  logic [N-1:0]          gnt_o, valid_o, err_o;
  logic [DW-1:0]         rdata_o, ad_wdata_o, ad_rdata_i = '0;
  logic [IW-1:0]         id_o, ad_id_o, ad_id_i = '0;
  logic                  busy_o, ad_req_o, ad_type_o, ad_we_o;
  logic [2:0]            ad_size_o;
  logic [AW-1:0]         ad_addr_o;
  logic [DW/8-1:0]       ad_be_o;
  logic                  ad_gnt_i = 1'b0, ad_valid_i = 1'b0;

  axi_req_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .ARB_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .type_i(type_i), .we_i(we_i),
    .size_i(size_i), .id_i(id_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .valid_o(valid_o), .rdata_o(rdata_o), .id_o(id_o), .err_o(err_o),
    .busy_o(busy_o), .ad_req_o(ad_req_o), .ad_type_o(ad_type_o), .ad_we_o(ad_we_o),
    .ad_size_o(ad_size_o), .ad_id_o(ad_id_o), .ad_addr_o(ad_addr_o),
    .ad_wdata_o(ad_wdata_o), .ad_be_o(ad_be_o), .ad_gnt_i(ad_gnt_i),
    .ad_valid_i(ad_valid_i), .ad_rdata_i(ad_rdata_i), .ad_id_i(ad_id_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [N-1:0] vec; logic [AW-1:0] addr; logic [IW-1:0] id; int fwd; int idle; } gexp_t;
  typedef struct { logic [N-1:0] vec; logic [DW-1:0] data; logic [IW-1:0] id; int dly; } rexp_t;
  typedef struct { logic [N-1:0] vec; int dly; } eexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  eexp_t eq[$];

  int checks = 0, errors = 0;
  int pend[N];
  int gnt_wait = 0, rsp_wait = 1;
  bit rsp_en = 1, rsp_fixed = 0, vld_on_gnt = 0;
  logic [DW-1:0] rsp_data = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [N-1:0] v);
    checks++;
    errors++;
    $display("FAIL %s: got %0b, want no event", name, v);
  endtask

  function automatic logic [AW-1:0] addr_of(input int r);
    return 64'h1000 + 64'(r) * 64'h100;
  endfunction

  function automatic logic [IW-1:0] id_of(input int r);
    return 10'h10 + 10'(r);
  endfunction

  task automatic push_g(input int r, input int fwd, input int idle);
    gq.push_back('{vec: 3'(1 << r), addr: addr_of(r), id: id_of(r), fwd: fwd, idle: idle});
  endtask

  task automatic push_r(input int r, input logic [DW-1:0] data);
    rq.push_back('{vec: 3'(1 << r), data: data, id: id_of(r), dly: 2});
  endtask

  // Requesters: req_i[i] stays high while it still has transactions to issue.
  always @(posedge clk_i) begin
    #1;
    for (int i = 0; i < N; i++) req_i[i] = (pend[i] > 0);
  end

  always @(negedge clk_i)
    for (int k = 0; k < N; k++) if (gnt_o[k] && pend[k] > 0) pend[k]--;

  // Adapter model: grants after gnt_wait extra FWD cycles, responds rsp_wait cycles later.
  int a_ph = 0, a_cnt = 0;
  logic [AW-1:0] cap_addr = '0;
  logic [IW-1:0] cap_id = '0;
  always @(posedge clk_i) begin
    #1;
    ad_gnt_i   = 1'b0;
    ad_valid_i = 1'b0;
    if (!rst_ni) begin
      a_ph = 0; a_cnt = 0;
    end else if (a_ph == 0) begin
      if (ad_req_o) begin
        if (a_cnt == gnt_wait) begin
          ad_gnt_i = 1'b1;
          cap_addr = ad_addr_o;
          cap_id   = ad_id_o;
          if (vld_on_gnt) begin
            ad_valid_i = 1'b1;
            ad_rdata_i = '1;
            vld_on_gnt = 0;
          end
          a_ph = 1; a_cnt = 0;
        end else a_cnt++;
      end
    end else if (rsp_en && a_cnt == rsp_wait) begin
      ad_valid_i = 1'b1;
      ad_rdata_i = rsp_fixed ? rsp_data : {4{cap_addr}};
      ad_id_i    = cap_id;
      a_ph = 0; a_cnt = 0;
    end else a_cnt++;
  end

  // Monitor / scoreboard
  int fwd_cnt = 0, idle_cnt = 0, idle_seen = 0, since_gnt = 0;
  always @(negedge clk_i) begin
    gexp_t g;
    rexp_t r;
    eexp_t e;
    if (!busy_o) idle_cnt++;
    else begin
      if (ad_req_o && fwd_cnt == 0) idle_seen = idle_cnt;
      idle_cnt = 0;
    end
    if (ad_req_o) fwd_cnt++; else fwd_cnt = 0;
    if (gnt_o != 0) since_gnt = 0; else since_gnt++;
    if (rst_ni) begin
      if (gnt_o != 0) begin
        if (gq.size() == 0) unexp("gnt_unexpected", gnt_o);
        else begin
          g = gq.pop_front();
          chk("gnt_vec", DW'(gnt_o), DW'(g.vec));
          chk("gnt_with_ad_gnt", DW'(ad_gnt_i), DW'(1));
          chk("gnt_addr", DW'(ad_addr_o), DW'(g.addr));
          chk("gnt_id", DW'(ad_id_o), DW'(g.id));
          chk("gnt_fwd_len", DW'(fwd_cnt), DW'(g.fwd));
          if (g.idle >= 0) chk("gnt_idle_len", DW'(idle_seen), DW'(g.idle));
        end
      end
      if (valid_o != 0) begin
        if (rq.size() == 0) unexp("valid_unexpected", valid_o);
        else begin
          r = rq.pop_front();
          chk("rsp_vec", DW'(valid_o), DW'(r.vec));
          chk("rsp_rdata", rdata_o, r.data);
          chk("rsp_id", DW'(id_o), DW'(r.id));
          chk("rsp_delay", DW'(since_gnt), DW'(r.dly));
        end
      end
      if (err_o != 0) begin
        if (eq.size() == 0) unexp("err_unexpected", err_o);
        else begin
          e = eq.pop_front();
          chk("err_vec", DW'(err_o), DW'(e.vec));
          chk("err_delay", DW'(since_gnt), DW'(e.dly));
          chk("err_no_valid", DW'(valid_o), DW'(0));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    gnt_wait = 0; rsp_wait = 1; rsp_en = 1; rsp_fixed = 0; vld_on_gnt = 0;
    #1;
    chk("reset_outputs", DW'({gnt_o, valid_o, err_o, busy_o, ad_req_o}), DW'(0));
    chk("reset_park_addr", DW'(ad_addr_o), DW'(addr_of(0)));
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    bit done = 0;
    while (!done && n < maxc) begin
      @(negedge clk_i);
      #2;
      n++;
      done = (gq.size() == 0 && rq.size() == 0 && eq.size() == 0 && !busy_o &&
              pend[0] == 0 && pend[1] == 0 && pend[2] == 0);
    end
    chk("wait_done_timeout", DW'(done), DW'(1));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      size_i[i]  = 3'd5;
      id_i[i]    = id_of(i);
      addr_i[i]  = addr_of(i);
      wdata_i[i] = {8{32'hC0DE0000 + 32'(i)}};
      be_i[i]    = '1;
      pend[i]    = 0;
    end

    // Round robin with all requesters active; first grant also sees a same-cycle ad_valid_i.
    do_reset();
    @(negedge clk_i);
    #1;
    pend[0] = 2; pend[1] = 1; pend[2] = 1;
    vld_on_gnt = 1;
    push_g(0, 1, -1); push_g(1, 1, 1); push_g(2, 1, 1); push_g(0, 1, 1);
    for (int r = 0; r < 4; r++) push_r(r % 3, {4{addr_of(r % 3)}});
    @(negedge clk_i);
    chk("latency_req_seen", DW'(req_i), DW'(3'b111));
    chk("latency_ad_req_low", DW'(ad_req_o), DW'(0));
    @(negedge clk_i);
    chk("latency_ad_req_high", DW'(ad_req_o), DW'(1));
    wait_done(80);

    // Lone high requester from rr 0, then stalled grant with a fixed read line.
    do_reset();
    #1 pend[2] = 1;
    push_g(2, 1, -1);
    push_r(2, {4{addr_of(2)}});
    wait_done(30);
    #1;
    gnt_wait = 5; rsp_fixed = 1; rsp_data = {32{8'hA5}};
    pend[1] = 1;
    push_g(1, 6, -1);
    push_r(1, {32{8'hA5}});
    wait_done(30);

    // Reset while waiting for a response abandons it silently.
    do_reset();
    #1 rsp_en = 0; pend[0] = 1;
    push_g(0, 1, -1);
    for (int n = 0; n < 20 && gq.size() != 0; n++) begin
      @(negedge clk_i);
      #2;
    end
    @(negedge clk_i);
    chk("in_wait_rsp_busy", DW'(busy_o), DW'(1));
    do_reset();
    #1 pend[1] = 1;
    push_g(1, 1, -1);
    push_r(1, {4{addr_of(1)}});
    wait_done(30);

    // Response never arrives.
    do_reset();
    #1 rsp_en = 0; pend[1] = 1;
    push_g(1, 1, -1);
`ifdef AXI_ARB_TIMEOUT_EN
    eq.push_back('{vec: 3'b010, dly: 16});
    for (int n = 0; n < 40 && eq.size() != 0; n++) begin
      @(negedge clk_i);
      #2;
    end
    chk("timeout_seen", DW'(eq.size()), DW'(0));
    @(negedge clk_i);
    #2;
    chk("idle_after_timeout", DW'(busy_o), DW'(0));
`else
    repeat (40) @(negedge clk_i);
    #2;
    chk("still_waiting", DW'(busy_o), DW'(1));
    chk("no_err", DW'(err_o), DW'(0));
`endif
    do_reset();
    repeat (2) @(negedge clk_i);
    chk("queues_empty", DW'(gq.size() + rq.size() + eq.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
